// File: rtl/cnt_pkg.sv
// Shared types and configuration checks for the up/down counter family.
package cnt_pkg;

   // Behaviour at the range limits, selected per cycle by the sat input.
   typedef enum logic {
      CNT_WRAP = 1'b0,
      CNT_SAT  = 1'b1
   } cnt_mode_t;

   // True when a counter of the given width can represent 0..modulus-1
   // and the modulus is large enough to be a counter at all.
   function automatic bit modulus_fits(input int width, input int modulus);
      return (modulus >= 2) && ($clog2(modulus) <= width);
   endfunction

   // True when the largest step is no bigger than the largest count, so a
   // single wrap can never overshoot the range more than once.
   function automatic bit step_fits(input int step_w, input int modulus);
      return ((2 ** step_w) - 1) <= (modulus - 1);
   endfunction

endpackage : cnt_pkg

// File: rtl/cnt_next.sv
// Next-state arithmetic for the up/down counter: one step up or down with
// wrap-around or saturation at 0 / MODULUS-1, plus an out-of-range flag.
module cnt_next
   import cnt_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16,
   parameter int STEP_W  = 2
) (
   input  logic [WIDTH-1:0]  q,
   input  logic [STEP_W-1:0] step,
   input  logic              down,
   input  logic              sat,
   output logic [WIDTH-1:0]  q_next,
   output logic              ovf_next
);

   // Arithmetic is carried one bit wider so MODULUS itself and q+step are
   // representable even when MODULUS == 2**WIDTH.
   localparam logic [WIDTH:0]   MOD_S = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0]   MAX_S = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

   cnt_mode_t        mode;
   logic [WIDTH:0]   q_w;
   logic [WIDTH:0]   step_w;
   logic [WIDTH:0]   sum_w;

   assign mode   = cnt_mode_t'(sat);
   assign q_w    = (WIDTH+1)'(q);
   assign step_w = (WIDTH+1)'(step);
   assign sum_w  = q_w + step_w;

   // Pick the in-range result or the wrapped/clamped one for this direction.
   always_comb begin
      // NOTE: every output gets a default before any branch so no path can
      // leave it unassigned and infer a latch.
      q_next   = q;
      ovf_next = 1'b0;
      if (!down) begin
         if (sum_w <= MAX_S) begin
            q_next = WIDTH'(sum_w);
         end else begin
            ovf_next = 1'b1;
            q_next   = (mode == CNT_SAT) ? MAX_Q : WIDTH'(sum_w - MOD_S);
         end
      end else begin
         if (q_w >= step_w) begin
            q_next = WIDTH'(q_w - step_w);
         end else begin
            ovf_next = 1'b1;
            q_next   = (mode == CNT_SAT) ? '0 : WIDTH'(q_w + MOD_S - step_w);
         end
      end
   end

endmodule : cnt_next

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with programmable step, wrap/saturate mode,
// parallel load and terminal-count flag. Holds only the count and the
// overflow pulse; all arithmetic lives in cnt_next.
module mod_updown_counter
   import cnt_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16,
   parameter int STEP_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              down,
   input  logic [STEP_W-1:0] step,
   input  logic              sat,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   output logic [WIDTH-1:0]  q,
   output logic              tc,
   output logic              ovf
);

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

   // Reject configurations that cannot hold the range or could overshoot it.
   if (!modulus_fits(WIDTH, MODULUS)) begin : g_bad_modulus
      $error("mod_updown_counter: MODULUS=%0d does not fit WIDTH=%0d", MODULUS, WIDTH);
   end
   if (!step_fits(STEP_W, MODULUS)) begin : g_bad_step
      $error("mod_updown_counter: STEP_W=%0d too wide for MODULUS=%0d", STEP_W, MODULUS);
   end

   logic [WIDTH-1:0] q_q, q_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] q_step;
   logic             ovf_step;
   logic [WIDTH-1:0] load_clamped;

   cnt_next #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS),
      .STEP_W  (STEP_W)
   ) u_cnt_next (
      .q        (q_q),
      .step     (step),
      .down     (down),
      .sat      (sat),
      .q_next   (q_step),
      .ovf_next (ovf_step)
   );

   // Out-of-range load values are clamped so q never leaves 0..MODULUS-1.
   assign load_clamped = (load_val > MAX_Q) ? MAX_Q : load_val;

   // Load beats counting; an idle cycle holds q and clears the pulse.
   always_comb begin
      q_d   = q_q;
      ovf_d = 1'b0;
      if (load) begin
         q_d = load_clamped;
      end else if (en) begin
         q_d   = q_step;
         ovf_d = ovf_step;
      end
   end

   // State register; reset wins over any load or count on the same edge.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      if (rst) begin
         q_q   <= '0;
         ovf_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         ovf_q <= ovf_d;
      end
   end

   assign q   = q_q;
   assign ovf = ovf_q;
   assign tc  = down ? (q_q == '0) : (q_q == MAX_Q);

endmodule : mod_updown_counter

// File: tb/tb_mod_updown_counter.sv
// Directed bench: a MODULUS=10 counter for the main scenarios and a
// MODULUS=16 counter for the full-range free-run, sharing one stimulus.
module tb_mod_updown_counter;

   logic       clk = 1'b0;
   logic       rst, en, down, sat, load;
   logic [1:0] step;
   logic [3:0] load_val;
   logic [3:0] q10, q16;
   logic       tc10, tc16, ovf10, ovf16;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .STEP_W(2)) dut10 (
      .clk(clk), .rst(rst), .en(en), .down(down), .step(step), .sat(sat),
      .load(load), .load_val(load_val), .q(q10), .tc(tc10), .ovf(ovf10)
   );

   mod_updown_counter #(.WIDTH(4), .MODULUS(16), .STEP_W(2)) dut16 (
      .clk(clk), .rst(rst), .en(en), .down(down), .step(step), .sat(sat),
      .load(load), .load_val(load_val), .q(q16), .tc(tc16), .ovf(ovf16)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge, then settle before sampling and re-driving inputs.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "bench timed out");
   end

   initial begin
      rst = 1'b1; en = 1'b0; down = 1'b0; sat = 1'b0;
      load = 1'b0; step = 2'd0; load_val = 4'd0;

      // 1. reset state and tc polarity
      tick();
      check("rst_q",     32'(q10),   0);
      check("rst_ovf",   32'(ovf10), 0);
      check("rst_tc_up", 32'(tc10),  0);
      check("rst_q16",   32'(q16),   0);
      down = 1'b1; #1;
      check("rst_tc_dn", 32'(tc10),  1);

      // 2. up wrap
      rst = 1'b0; down = 1'b0; load = 1'b1; load_val = 4'd8;
      tick();
      check("ld8_q", 32'(q10), 8);
      load = 1'b0; en = 1'b1; step = 2'd3; sat = 1'b0;
      tick();
      check("upwrap_q",   32'(q10),   1);
      check("upwrap_ovf", 32'(ovf10), 1);
      tick();
      check("up4_q",   32'(q10),   4);
      check("up4_ovf", 32'(ovf10), 0);

      // 3. down wrap
      en = 1'b0; load = 1'b1; load_val = 4'd1;
      tick();
      check("ld1_q", 32'(q10), 1);
      load = 1'b0; en = 1'b1; down = 1'b1; step = 2'd2;
      tick();
      check("dnwrap_q",   32'(q10),   9);
      check("dnwrap_ovf", 32'(ovf10), 1);
      check("dnwrap_tc",  32'(tc10),  0);
      step = 2'd1;
      tick();
      check("dn8_q",   32'(q10),   8);
      check("dn8_ovf", 32'(ovf10), 0);

      // 4. up saturate, repeated clamp, step 0 and en 0 hold
      down = 1'b0; en = 1'b0; load = 1'b1; load_val = 4'd8;
      tick();
      load = 1'b0; en = 1'b1; step = 2'd3; sat = 1'b1;
      tick();
      check("upsat_q",   32'(q10),   9);
      check("upsat_ovf", 32'(ovf10), 1);
      check("upsat_tc",  32'(tc10),  1);
      tick();
      check("upsat2_q",   32'(q10),   9);
      check("upsat2_ovf", 32'(ovf10), 1);
      step = 2'd0;
      tick();
      check("step0_q",   32'(q10),   9);
      check("step0_ovf", 32'(ovf10), 0);
      step = 2'd3; en = 1'b0;
      tick();
      check("en0_q",   32'(q10),   9);
      check("en0_ovf", 32'(ovf10), 0);

      // down saturate at 0
      load = 1'b1; load_val = 4'd1;
      tick();
      load = 1'b0; en = 1'b1; down = 1'b1; step = 2'd3;
      tick();
      check("dnsat_q",   32'(q10),   0);
      check("dnsat_ovf", 32'(ovf10), 1);
      check("dnsat_tc",  32'(tc10),  1);

      // 5. load clamp and load priority over count
      down = 1'b0; sat = 1'b0; en = 1'b0; load = 1'b1; load_val = 4'd12;
      tick();
      check("ldclamp_q",   32'(q10),   9);
      check("ldclamp_ovf", 32'(ovf10), 0);
      load_val = 4'd2;
      tick();
      check("ld2_q", 32'(q10), 2);
      load_val = 4'd12; en = 1'b1; step = 2'd3;
      tick();
      check("ldwin_q",   32'(q10),   9);
      check("ldwin_ovf", 32'(ovf10), 0);

      // 6. reset beats load mid-count, then MODULUS=16 free-run
      load = 1'b0; en = 1'b1; step = 2'd3;
      tick();
      check("pre_rst_q",   32'(q10),   2);
      check("pre_rst_ovf", 32'(ovf10), 1);
      rst = 1'b1; load = 1'b1; load_val = 4'd5;
      tick();
      check("rstwin_q",   32'(q10),   0);
      check("rstwin_ovf", 32'(ovf10), 0);
      check("rstwin_q16", 32'(q16),   0);
      rst = 1'b0; load = 1'b0; en = 1'b1; down = 1'b0; sat = 1'b0; step = 2'd1;
      for (int i = 1; i <= 15; i++) begin
         tick();
         check("free_q16",   32'(q16),   32'(i));
         check("free_ovf16", 32'(ovf16), 0);
         check("free_tc16",  32'(tc16),  (i == 15) ? 32'd1 : 32'd0);
      end
      tick();
      check("free_wrap_q16",   32'(q16),   0);
      check("free_wrap_ovf16", 32'(ovf16), 1);
      check("free_wrap_tc16",  32'(tc16),  0);
      tick();
      check("free_after_q16",   32'(q16),   1);
      check("free_after_ovf16", 32'(ovf16), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mod_updown_counter
